// File: rtl/sdu_seq_ctrl.sv
// Transmit-path sequencer: emits num_pulses bursts at a fixed PRI and places an rx capture gate in each PRI.
// Optional external-trigger gating of every PRI is compiled in with `define SDU_SEQ_TRIG_EN.
module sdu_seq_ctrl #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] seq_len,
    input  logic [CW-1:0] period,
    input  logic [CW-1:0] num_pulses,
    input  logic [CW-1:0] rx_delay,
    input  logic [CW-1:0] rx_len,
`ifdef SDU_SEQ_TRIG_EN
    input  logic          ext_trig,
`endif
    output logic          sdu_tx_en,
    output logic          sdu_seq_done_strobe,
    output logic          rx_gate,
    output logic          busy,
    output logic [CW-1:0] pulse_idx,
    output logic          done
);

    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_TRIG} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc, cyc_e, idx_e;
    logic          enter, load, last_e, fin_e;

    logic [CW-1:0] seq_len_r, p_r, num_r, rxd_r;
    logic [CW:0]   rxe_r;
    logic [CW-1:0] seq_e, p_e, num_e, rxd_e, p_in;
    logic [CW:0]   rxe_e;

`ifdef SDU_SEQ_TRIG_EN
    logic trig_prev;
    logic trig_rise;
    assign trig_rise = ext_trig && !trig_prev;
`endif

    // Effective PRI: never shorter than the burst, never zero.
    always_comb begin
        p_in = period;
        if (seq_len > p_in)
            p_in = seq_len;
        if (p_in == '0)
            p_in = ONE;
    end

    // Outputs are registered from the cycle being entered, so they line up with cyc.
    always_comb begin
        state_n = state;
        cyc_e   = cyc;
        idx_e   = pulse_idx;
        enter   = 1'b0;
        load    = 1'b0;
        seq_e   = seq_len_r;
        p_e     = p_r;
        num_e   = num_r;
        rxd_e   = rxd_r;
        rxe_e   = rxe_r;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load  = 1'b1;
                    seq_e = seq_len;
                    p_e   = p_in;
                    num_e = num_pulses;
                    rxd_e = rx_delay;
                    rxe_e = {1'b0, rx_delay} + {1'b0, rx_len};
                    cyc_e = '0;
                    idx_e = '0;
`ifdef SDU_SEQ_TRIG_EN
                    state_n = WAIT_TRIG;
`else
                    enter = 1'b1;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    cyc_e   = '0;
                end else if (cyc == p_r - ONE) begin
                    cyc_e = '0;
                    idx_e = pulse_idx + ONE;
`ifdef SDU_SEQ_TRIG_EN
                    state_n = WAIT_TRIG;
`else
                    enter = 1'b1;
`endif
                end else begin
                    cyc_e = cyc + ONE;
                    enter = 1'b1;
                end
            end
`ifdef SDU_SEQ_TRIG_EN
            WAIT_TRIG: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (trig_rise) begin
                    cyc_e = '0;
                    enter = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        last_e = (cyc_e == p_e - ONE);
        fin_e  = enter && last_e && (num_e != '0) && (idx_e == num_e - ONE);
        if (enter)
            state_n = fin_e ? IDLE : RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            cyc                 <= '0;
            pulse_idx           <= '0;
            sdu_tx_en           <= 1'b0;
            sdu_seq_done_strobe <= 1'b0;
            rx_gate             <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
`ifdef SDU_SEQ_TRIG_EN
            trig_prev           <= 1'b0;
`endif
        end else begin
            state               <= state_n;
            cyc                 <= cyc_e;
            pulse_idx           <= idx_e;
            sdu_tx_en           <= enter && (cyc_e < seq_e);
            sdu_seq_done_strobe <= enter && last_e;
            rx_gate             <= enter && (cyc_e >= rxd_e) && ({1'b0, cyc_e} < rxe_e);
            busy                <= (state_n != IDLE);
            done                <= fin_e;
`ifdef SDU_SEQ_TRIG_EN
            trig_prev           <= ext_trig;
`endif
        end
    end

    // Configuration snapshot taken only on an accepted start.
    always_ff @(posedge clk) begin
        if (load) begin
            seq_len_r <= seq_e;
            p_r       <= p_e;
            num_r     <= num_e;
            rxd_r     <= rxd_e;
            rxe_r     <= rxe_e;
        end
    end

endmodule

// File: tb/tb_sdu_seq_ctrl.sv
// Directed testbench for sdu_seq_ctrl; cycle k is the k-th cycle after the edge that sampled start.
module tb_sdu_seq_ctrl;

    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [CW-1:0] seq_len;
    logic [CW-1:0] period;
    logic [CW-1:0] num_pulses;
    logic [CW-1:0] rx_delay;
    logic [CW-1:0] rx_len;
`ifdef SDU_SEQ_TRIG_EN
    logic          ext_trig;
`endif
    logic          sdu_tx_en;
    logic          sdu_seq_done_strobe;
    logic          rx_gate;
    logic          busy;
    logic [CW-1:0] pulse_idx;
    logic          done;

    int checks = 0;
    int errors = 0;

    sdu_seq_ctrl #(.CW(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .abort               (abort),
        .seq_len             (seq_len),
        .period              (period),
        .num_pulses          (num_pulses),
        .rx_delay            (rx_delay),
        .rx_len              (rx_len),
`ifdef SDU_SEQ_TRIG_EN
        .ext_trig            (ext_trig),
`endif
        .sdu_tx_en           (sdu_tx_en),
        .sdu_seq_done_strobe (sdu_seq_done_strobe),
        .rx_gate             (rx_gate),
        .busy                (busy),
        .pulse_idx           (pulse_idx),
        .done                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] got_v;
        reset = 1'b1;
        step();
        step();
        step();
        got_v = {busy, sdu_tx_en, sdu_seq_done_strobe, done, rx_gate};
        checks++;
        if (got_v !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000", got_v);
        end
        checks++;
        if (pulse_idx !== 16'd0) begin
            errors++;
            $display("FAIL reset_pulse_idx got %0d exp 0", pulse_idx);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [4:0] exp_v, got_v;
        int exp_idx;
        seq_len = 4; period = 10; num_pulses = 3; rx_delay = 0; rx_len = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            exp_v = {k <= 29, (k <= 30) && (((k - 1) % 10) < 4),
                     (k == 10 || k == 20 || k == 30), k == 30, 1'b0};
            exp_idx = (k <= 30) ? (k - 1) / 10 : 2;
            got_v = {busy, sdu_tx_en, sdu_seq_done_strobe, done, rx_gate};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL basic k=%0d {busy,tx,strb,done,rx} got %b exp %b", k, got_v, exp_v);
            end
            checks++;
            if (pulse_idx !== 16'(exp_idx)) begin
                errors++;
                $display("FAIL basic_idx k=%0d got %0d exp %0d", k, pulse_idx, exp_idx);
            end
            step();
        end
    endtask

    task automatic test_clamp();
        logic [4:0] exp_v, got_v;
        int exp_idx;
        seq_len = 8; period = 5; num_pulses = 2; rx_delay = 0; rx_len = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            exp_v = {k <= 15, k <= 16, (k == 8 || k == 16), k == 16, 1'b0};
            exp_idx = (k <= 8) ? 0 : 1;
            got_v = {busy, sdu_tx_en, sdu_seq_done_strobe, done, rx_gate};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL clamp k=%0d {busy,tx,strb,done,rx} got %b exp %b", k, got_v, exp_v);
            end
            checks++;
            if (pulse_idx !== 16'(exp_idx)) begin
                errors++;
                $display("FAIL clamp_idx k=%0d got %0d exp %0d", k, pulse_idx, exp_idx);
            end
            step();
        end
    endtask

    task automatic test_rx_gate();
        logic [4:0] exp_v, got_v;
        int c;
        seq_len = 2; period = 12; num_pulses = 2; rx_delay = 6; rx_len = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            c = (k - 1) % 12;
            exp_v = {k <= 23, (k <= 24) && (c < 2), (k == 12 || k == 24), k == 24,
                     (k <= 24) && (c >= 6) && (c <= 8)};
            got_v = {busy, sdu_tx_en, sdu_seq_done_strobe, done, rx_gate};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL rx_gate k=%0d {busy,tx,strb,done,rx} got %b exp %b", k, got_v, exp_v);
            end
            step();
        end
        rx_len = 0; num_pulses = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            checks++;
            if (rx_gate !== 1'b0) begin
                errors++;
                $display("FAIL rx_len_zero k=%0d got %b exp 0", k, rx_gate);
            end
            step();
        end
    endtask

    task automatic test_infinite_abort();
        int strobes = 0;
        int dones = 0;
        seq_len = 1; period = 4; num_pulses = 0; rx_delay = 0; rx_len = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (sdu_seq_done_strobe === 1'b1) strobes++;
            if (done === 1'b1) dones++;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL inf_busy k=%0d got %b exp 1", k, busy);
            end
            if (k == 40) begin
                checks++;
                if (pulse_idx !== 16'd9) begin
                    errors++;
                    $display("FAIL inf_idx got %0d exp 9", pulse_idx);
                end
                abort = 1'b1;
            end
            step();
        end
        abort = 1'b0;
        checks++;
        if ({busy, sdu_tx_en, sdu_seq_done_strobe, done, rx_gate} !== 5'b0) begin
            errors++;
            $display("FAIL abort_outputs got %b exp 00000",
                     {busy, sdu_tx_en, sdu_seq_done_strobe, done, rx_gate});
        end
        checks++;
        if (strobes !== 10) begin
            errors++;
            $display("FAIL inf_strobes got %0d exp 10", strobes);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL inf_done got %0d exp 0", dones);
        end
        step();
    endtask

    task automatic test_start_ignored();
        logic [4:0] exp_v, got_v;
        int exp_idx;
        seq_len = 2; period = 6; num_pulses = 2; rx_delay = 0; rx_len = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            exp_v = {k <= 11, (k <= 12) && (((k - 1) % 6) < 2), (k == 6 || k == 12), k == 12, 1'b0};
            exp_idx = (k <= 12) ? (k - 1) / 6 : 1;
            got_v = {busy, sdu_tx_en, sdu_seq_done_strobe, done, rx_gate};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL restart k=%0d {busy,tx,strb,done,rx} got %b exp %b", k, got_v, exp_v);
            end
            checks++;
            if (pulse_idx !== 16'(exp_idx)) begin
                errors++;
                $display("FAIL restart_idx k=%0d got %0d exp %0d", k, pulse_idx, exp_idx);
            end
            if (k == 3) begin
                start = 1'b1;
                seq_len = 7; period = 20; num_pulses = 5;
            end
            step();
            start = 1'b0;
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({busy, sdu_tx_en} !== 2'b00) begin
                errors++;
                $display("FAIL start_abort k=%0d {busy,tx} got %b exp 00", k, {busy, sdu_tx_en});
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp_v, got_v;
        seq_len = 4; period = 10; num_pulses = 3; rx_delay = 0; rx_len = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        got_v = {busy, sdu_tx_en, sdu_seq_done_strobe, done, rx_gate};
        checks++;
        if (got_v !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b exp 00000", got_v);
        end
        checks++;
        if (pulse_idx !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_idx got %0d exp 0", pulse_idx);
        end
        step();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_idle {busy,done} got %b exp 00", {busy, done});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            exp_v = {k <= 29, ((k - 1) % 10) < 4, (k == 10 || k == 20 || k == 30), k == 30, 1'b0};
            got_v = {busy, sdu_tx_en, sdu_seq_done_strobe, done, rx_gate};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL replay k=%0d {busy,tx,strb,done,rx} got %b exp %b", k, got_v, exp_v);
            end
            checks++;
            if (pulse_idx !== 16'((k - 1) / 10)) begin
                errors++;
                $display("FAIL replay_idx k=%0d got %0d exp %0d", k, pulse_idx, (k - 1) / 10);
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        seq_len = '0; period = '0; num_pulses = '0; rx_delay = '0; rx_len = '0;
`ifdef SDU_SEQ_TRIG_EN
        ext_trig = 1'b0;
`endif
        #1;
        test_reset();
        test_basic();
        test_clamp();
        test_rx_gate();
        test_infinite_abort();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
